// File: rtl/char_cell_scanner.sv
// Character-cell pixel scanner: sweeps a CHAR_W x CHAR_H cell per character of a string.
// Defining CHAR_CELL_SCANNER_ABORT_EN adds an abort input that cancels a running string.
module char_cell_scanner #(
    parameter int unsigned CHAR_W = 8,
    parameter int unsigned CHAR_H = 8,
    parameter int unsigned XW     = 3,
    parameter int unsigned YW     = 3,
    parameter int unsigned IW     = 4
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic [IW:0]   num_chars,
    input  logic          stall,
`ifdef CHAR_CELL_SCANNER_ABORT_EN
    input  logic          abort,
`endif
    output logic [XW-1:0] px_x,
    output logic [YW-1:0] px_y,
    output logic [IW-1:0] char_idx,
    output logic          plot,
    output logic          char_done,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state;
    logic [IW:0] count;
    logic        abort_req;
    logic        last_x;
    logic        last_y;
    logic        last_char;

`ifdef CHAR_CELL_SCANNER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Compare against parameter-1 so non-power-of-two cells wrap correctly.
    assign last_x    = (px_x == XW'(CHAR_W - 1));
    assign last_y    = (px_y == YW'(CHAR_H - 1));
    assign last_char = (({1'b0, char_idx} + (IW + 1)'(1)) == count);

    assign busy      = (state != StIdle);
    assign plot      = (state == StRun) && !stall && !abort_req;
    assign char_done = plot && last_x && last_y;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= StIdle;
            px_x     <= '0;
            px_y     <= '0;
            char_idx <= '0;
            count    <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (start) begin
                        px_x     <= '0;
                        px_y     <= '0;
                        char_idx <= '0;
                        count    <= num_chars;
                        if (num_chars == '0) begin
                            state <= StDone;
                            done  <= 1'b1;
                        end else begin
                            state <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (abort_req) begin
                        state    <= StIdle;
                        px_x     <= '0;
                        px_y     <= '0;
                        char_idx <= '0;
                    end else if (char_done) begin
                        px_x <= '0;
                        px_y <= '0;
                        // Clearing on the final character keeps a full 2^IW string unambiguous.
                        if (last_char) begin
                            state    <= StDone;
                            done     <= 1'b1;
                            char_idx <= '0;
                        end else begin
                            char_idx <= char_idx + IW'(1);
                        end
                    end else if (plot) begin
                        if (last_x) begin
                            px_x <= '0;
                            px_y <= px_y + YW'(1);
                        end else begin
                            px_x <= px_x + XW'(1);
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_char_cell_scanner.sv
// Scoreboard bench for char_cell_scanner: an 8x8 instance and a 5x7 instance.
// Driver pushes expected pixels; per-instance monitors pop and compare on every plot.
module tb_char_cell_scanner;

    localparam int CW = 8, CH = 8, CW2 = 5, CH2 = 7, XW = 3, YW = 3, IW = 4;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [IW-1:0] idx;
        logic          cd;
    } pix_t;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0, start2 = 1'b0, stall = 1'b0;
    logic [IW:0]   num_chars = '0, num2 = '0;
    logic [XW-1:0] px_x, px_x2;
    logic [YW-1:0] px_y, px_y2;
    logic [IW-1:0] char_idx, char_idx2;
    logic          plot, char_done, busy, done;
    logic          plot2, char_done2, busy2, done2;
`ifdef CHAR_CELL_SCANNER_ABORT_EN
    logic          abort = 1'b0;
`endif

    pix_t exp_q[$], exp2_q[$];
    int   n_chk = 0, n_fail = 0;
    int   plot_cnt = 0, plot2_cnt = 0, done_cnt = 0, done2_cnt = 0;
    int   exp_done = 0, exp_done2 = 0;

    always #5 clock = ~clock;

    char_cell_scanner #(.CHAR_W(CW), .CHAR_H(CH), .XW(XW), .YW(YW), .IW(IW)) dut (
        .clock(clock), .resetn(resetn), .start(start), .num_chars(num_chars), .stall(stall),
`ifdef CHAR_CELL_SCANNER_ABORT_EN
        .abort(abort),
`endif
        .px_x(px_x), .px_y(px_y), .char_idx(char_idx), .plot(plot),
        .char_done(char_done), .busy(busy), .done(done)
    );

    char_cell_scanner #(.CHAR_W(CW2), .CHAR_H(CH2), .XW(XW), .YW(YW), .IW(IW)) dut2 (
        .clock(clock), .resetn(resetn), .start(start2), .num_chars(num2), .stall(1'b0),
`ifdef CHAR_CELL_SCANNER_ABORT_EN
        .abort(1'b0),
`endif
        .px_x(px_x2), .px_y(px_y2), .char_idx(char_idx2), .plot(plot2),
        .char_done(char_done2), .busy(busy2), .done(done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor for the 8x8 instance.
    always @(negedge clock) begin
        pix_t e;
        if (resetn) begin
            check("char_done_gated", char_done && !plot, 0);
            if (plot) begin
                plot_cnt++;
                check("expect_available", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pixel", {px_x, px_y, char_idx, char_done}, e);
                end
            end else if (stall && busy && !done && exp_q.size() > 0) begin
                check("stall_freeze", {px_x, px_y, char_idx}, {exp_q[0].x, exp_q[0].y, exp_q[0].idx});
            end
            if (done) begin
                done_cnt++;
                check("done_queue_empty", exp_q.size(), 0);
            end
        end
    end

    // Monitor for the 5x7 instance.
    always @(negedge clock) begin
        pix_t e;
        if (resetn) begin
            check("char_done2_gated", char_done2 && !plot2, 0);
            if (plot2) begin
                plot2_cnt++;
                check("expect2_available", exp2_q.size() > 0, 1);
                if (exp2_q.size() > 0) begin
                    e = exp2_q.pop_front();
                    check("pixel2", {px_x2, px_y2, char_idx2, char_done2}, e);
                end
            end
            if (done2) begin
                done2_cnt++;
                check("done2_queue_empty", exp2_q.size(), 0);
            end
        end
    end

    task automatic push_pixels(input bit sec, input int n, input int limit);
        int w = sec ? CW2 : CW;
        int h = sec ? CH2 : CH;
        int k = 0;
        for (int ch = 0; ch < n; ch++)
            for (int y = 0; y < h; y++)
                for (int x = 0; x < w; x++) begin
                    pix_t p;
                    p.x   = XW'(x);
                    p.y   = YW'(y);
                    p.idx = IW'(ch);
                    p.cd  = (x == w - 1) && (y == h - 1);
                    if (limit < 0 || k < limit) begin
                        if (sec) exp2_q.push_back(p);
                        else exp_q.push_back(p);
                    end
                    k++;
                end
    endtask

    // Issue a start so it is accepted at the next edge; returns in cycle 1.
    task automatic issue_start(input bit sec, input int n);
        @(posedge clock); #1;
        if (sec) begin start2 = 1'b1; num2 = (IW + 1)'(n); end
        else begin start = 1'b1; num_chars = (IW + 1)'(n); end
        @(posedge clock); #1;
        start  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic run(input bit sec, input int n, input bit stall_mode, input int exp_lat,
                       input int restart_at);
        int lat = 0;
        int p0  = sec ? plot2_cnt : plot_cnt;
        int w   = sec ? CW2 : CW;
        int h   = sec ? CH2 : CH;
        push_pixels(sec, n, -1);
        issue_start(sec, n);
        for (int c = 1; c <= 3000 && lat == 0; c++) begin
            if (c > 1) begin @(posedge clock); #1; end
            stall = stall_mode && (c % 2 == 1);
            if (c == restart_at) begin start = 1'b1; num_chars = 5'd2; end
            else if (c == restart_at + 1) start = 1'b0;
            check("busy_run", sec ? busy2 : busy, 1);
            if (sec ? done2 : done) lat = c;
        end
        stall = 1'b0;
        start = 1'b0;
        if (sec) exp_done2++; else exp_done++;
        check("latency", lat, exp_lat);
        @(posedge clock); #1;
        if (sec) check("idle_after2", {busy2, done2, plot2, px_x2, px_y2, char_idx2}, 0);
        else check("idle_after", {busy, done, plot, px_x, px_y, char_idx}, 0);
        check("plot_count", (sec ? plot2_cnt : plot_cnt) - p0, n * w * h);
    endtask

    initial begin
        #2;
        check("reset_outputs", {px_x, px_y, char_idx, plot, char_done, busy, done}, 0);
        #10 resetn = 1'b1;

        run(0, 1, 0, 65, 0);
        run(0, 3, 1, 385, 0);
        run(0, 0, 0, 1, 0);
        run(0, 16, 0, 1025, 100);
        run(1, 2, 0, 71, 0);

        // Asynchronous reset mid-string.
        push_pixels(0, 2, -1);
        issue_start(0, 2);
        repeat (30) @(posedge clock);
        #3 resetn = 1'b0;
        #1 check("async_reset", {px_x, px_y, char_idx, plot, char_done, busy, done}, 0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #3 resetn = 1'b1;
        run(0, 1, 0, 65, 0);

`ifdef CHAR_CELL_SCANNER_ABORT_EN
        push_pixels(0, 2, 20);
        issue_start(0, 2);
        repeat (20) begin @(posedge clock); #1; end
        abort = 1'b1;
        #1 check("abort_plot_forced", {plot, char_done}, 0);
        @(posedge clock); #1;
        abort = 1'b0;
        check("abort_idle", {busy, done, px_x, px_y, char_idx}, 0);
        check("abort_consumed", exp_q.size(), 0);
        abort = 1'b1;
        run(0, 0, 0, 1, 0);
        abort = 1'b0;
        run(0, 1, 0, 65, 0);
`endif

        repeat (2) @(posedge clock);
        #1;
        check("done_count", done_cnt, exp_done);
        check("done2_count", done2_cnt, exp_done2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/char_cell_scanner.md
Name: char_cell_scanner

Overview:
- Parametrised successor to the single-character pixel counter in the VGA path.
- Walks every pixel of a CHAR_W x CHAR_H glyph cell for each character of a string of up to MAX_CHARS characters.
- Presents x/y offsets and the character index to the glyph-ROM/plot stage, with a start/busy/done handshake and a stall input for back-pressure from the VGA adapter.
- Pulses a per-character completion flag and a string completion flag.

Parameters:
CHAR_W, 8, glyph width in pixels; 2..2^XW
CHAR_H, 8, glyph height in pixels; 2..2^YW
XW, 3, width of px_x
YW, 3, width of px_y
IW, 4, width of char_idx; MAX_CHARS = 2^IW

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  begin a string; sampled only in IDLE
num_chars  in  IW+1  characters to draw, 0..2^IW; latched on accepted start
stall  in  1  downstream not ready; freezes counters while high
px_x  out  XW  column offset within current cell
px_y  out  YW  row offset within current cell
char_idx  out  IW  index of current character
plot  out  1  current px_x/px_y/char_idx valid and consumed this cycle
char_done  out  1  last pixel of current character consumed this cycle
busy  out  1  high in RUN and DONE
done  out  1  one-cycle pulse, string complete

Behaviour:
- Reset: the clock and reset are fixed as one clock, `clock`, and an asynchronous active-low reset, `resetn`. While resetn=0: state=IDLE, px_x=0, px_y=0, char_idx=0, latched count=0, busy=0, done=0. plot=0 and char_done=0 as a consequence. Reset mid-string aborts immediately, with no done pulse.
- FSM states: IDLE, RUN, DONE. All state, counters and done are registered. plot and char_done are combinational from registered state, counters and stall.
- IDLE:
  - start=1 and num_chars=0 -> DONE.
  - start=1 and num_chars>0 -> RUN, with counters cleared and num_chars latched.
  - start=0 -> stay in IDLE.
- RUN:
  - plot = ~stall.
  - Counters advance only on cycles with plot=1. stall=1 holds every register.
  - Advance order: px_x+1. At px_x=CHAR_W-1, px_x wraps to 0 and px_y increments. At px_y=CHAR_H-1 with px_x=CHAR_W-1, px_y wraps to 0 and char_idx increments.
  - char_done = plot & (px_x=CHAR_W-1) & (px_y=CHAR_H-1).
  - char_done with char_idx = latched count-1 -> DONE. Counters clear to 0 on this transition, so the 2^IW-character case never wraps char_idx ambiguously.
- DONE: done=1 for exactly one cycle, then IDLE. plot=0.
- Latency: start accepted at edge 0. First pixel is presented from cycle 1. With no stall, the last pixel is in cycle N·CHAR_W·CHAR_H and done is high in the following cycle.
- start while busy: ignored, with no effect on the latched count.
- start asserted in the DONE cycle: ignored. A new start is accepted no earlier than the cycle after done.
- stall in IDLE/DONE: no effect.
- Arithmetic: counters are unsigned and compare against parameter-1, never relying on natural 2^n overflow. A non-power-of-two CHAR_W/CHAR_H must wrap correctly.

Optional Feature:
CHAR_CELL_SCANNER_ABORT_EN
- Defined: adds input abort (1 bit).
  - abort=1 in RUN (regardless of stall) -> IDLE on the next edge, counters cleared, no done and no char_done. plot is forced to 0 in that cycle.
  - abort in IDLE/DONE is ignored, so DONE still pulses.
- Undefined: the port does not exist. A string always runs to done unless resetn is asserted.

Test Plan:
1. Defaults, num_chars=1, start 1 cycle, stall=0 -> 64 plot cycles with (x,y) sweeping (0,0),(1,0)..(7,7) row-major. char_done only at (7,7). done high in cycle 65 after start. busy high in cycles 1-65.
2. num_chars=3, stall toggling every other cycle -> exactly 192 plot cycles. char_done at char_idx 0,1,2. Counters frozen on every stall cycle. done once.
3. num_chars=0 -> done one cycle after start, zero plot and char_done cycles, busy high for 1 cycle.
4. num_chars=16 (IW=4), plus a second start pulse mid-run with num_chars=2 -> 1024 plots. char_idx reaches 15 then returns to 0 in IDLE. The second start is ignored.
5. CHAR_W=5, CHAR_H=7, num_chars=2 -> px_x wraps at 4 and px_y at 6. 70 plots, done at cycle 71.
6. resetn low asynchronously mid-RUN (between edges) -> all outputs 0 immediately, no done. With the ABORT_EN build, abort at pixel 20 -> IDLE next edge, done never asserted, and a new start restarts from (0,0,0).
